// File: rtl/seg_scan_mux.sv
// Seven-segment scan multiplexer: drives four digits in turn on a shared cathode bus,
// with double-buffered pattern update, per-digit blanking and 8-level PWM brightness.
module seg_scan_mux #(
   parameter int SLOT_CYCLES = 100000,
   parameter bit ACTIVE_LOW  = 1'b1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [6:0] CX1,
   input  logic [6:0] CX2,
   input  logic [6:0] CX3,
   input  logic [6:0] CX4,
   input  logic       load,
   input  logic [3:0] blank,
   input  logic [2:0] brightness,
   output logic [3:0] an,
   output logic [6:0] seg,
   output logic       frame_tick,
   output logic [1:0] digit_idx
);

   // cnt and thresh share one width so that thresh can reach SLOT_CYCLES (full duty).
   localparam int              CW      = $clog2(SLOT_CYCLES + 1);
   localparam logic [CW-1:0]   LAST    = CW'(SLOT_CYCLES - 1);
   localparam logic [CW-1:0]   STEP    = CW'(SLOT_CYCLES / 8);
   localparam logic [3:0]      AN_OFF  = ACTIVE_LOW ? 4'b1111 : 4'b0000;
   localparam logic [6:0]      SEG_OFF = ACTIVE_LOW ? 7'h7F : 7'h00;

   // (level+1)*STEP built from shifted copies of STEP, one per set bit of level+1.
   function automatic logic [CW-1:0] slot_thresh(input logic [2:0] level);
      logic [3:0]    mult;
      logic [CW-1:0] acc;
      mult = {1'b0, level} + 4'd1;
      acc  = '0;
      for (int k = 0; k < 4; k++) begin
         if (mult[k]) begin
            acc = acc + (STEP << k);
         end else begin
            acc = acc;
         end
      end
      return acc;
   endfunction

   logic [CW-1:0] cnt_r;
   logic [1:0]    idx_r;
   logic [27:0]   staging_r;
   logic [27:0]   active_r;
   logic          pending_r;
   logic [2:0]    bright_r;
   logic [3:0]    an_r;
   logic [6:0]    seg_r;
   logic          frame_tick_r;
   logic [1:0]    digit_idx_r;

   logic          slot_end_s;
   logic          frame_end_s;
   logic [CW-1:0] thresh_s;
   logic          lit_s;
   logic [6:0]    pattern_s;
   logic [3:0]    an_next_s;
   logic [6:0]    seg_next_s;

   assign slot_end_s  = (cnt_r == LAST);
   assign frame_end_s = slot_end_s && (idx_r == 2'd3);
   assign thresh_s    = slot_thresh(bright_r);

   // Per-slot lit decision and the pre-polarity next values of an/seg.
   always_comb begin
      pattern_s  = 7'h00;
      an_next_s  = AN_OFF;
      seg_next_s = SEG_OFF;
      case (idx_r)
         2'd0:    pattern_s = active_r[6:0];
         2'd1:    pattern_s = active_r[13:7];
         2'd2:    pattern_s = active_r[20:14];
         2'd3:    pattern_s = active_r[27:21];
         default: pattern_s = 7'h00;
      endcase
      lit_s = (cnt_r < thresh_s) && !blank[idx_r];
      if (lit_s) begin
         an_next_s  = ACTIVE_LOW ? ~(4'b0001 << idx_r) : (4'b0001 << idx_r);
         seg_next_s = ACTIVE_LOW ? ~pattern_s : pattern_s;
      end else begin
         an_next_s  = AN_OFF;
         seg_next_s = SEG_OFF;
      end
   end

   // Slot counter, digit index and per-slot brightness sample.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_r    <= '0;
         idx_r    <= 2'd0;
         bright_r <= 3'd0;
      end else begin
         if (cnt_r == '0) begin
            bright_r <= brightness;
         end
         if (slot_end_s) begin
            cnt_r <= '0;
            idx_r <= idx_r + 2'd1;
         end else begin
            cnt_r <= cnt_r + CW'(1);
         end
      end
   end

   // Double buffer: a load at frame end bypasses staging so it is never left pending.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         staging_r <= 28'h0;
         active_r  <= 28'h0;
         pending_r <= 1'b0;
      end else if (load && frame_end_s) begin
         staging_r <= {CX4, CX3, CX2, CX1};
         active_r  <= {CX4, CX3, CX2, CX1};
         pending_r <= 1'b0;
      end else if (load) begin
         staging_r <= {CX4, CX3, CX2, CX1};
         pending_r <= 1'b1;
      end else if (frame_end_s && pending_r) begin
         active_r  <= staging_r;
         pending_r <= 1'b0;
      end
   end

   // Output register stage; an and seg always move on the same edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         an_r         <= AN_OFF;
         seg_r        <= SEG_OFF;
         frame_tick_r <= 1'b0;
         digit_idx_r  <= 2'd0;
      end else begin
         an_r         <= an_next_s;
         seg_r        <= seg_next_s;
         frame_tick_r <= frame_end_s;
         digit_idx_r  <= idx_r;
      end
   end

   assign an         = an_r;
   assign seg        = seg_r;
   assign frame_tick = frame_tick_r;
   assign digit_idx  = digit_idx_r;

endmodule
